// File: rtl/ebox_mem_pkg.sv
// ebox_mem_pkg: shared word/address types and MBOX request states for the EBOX memory path
package ebox_mem_pkg;
    localparam int WORD_W = 36;
    localparam int VMA_W = 23;
    typedef logic [0:WORD_W-1] word_t;
    typedef logic [36-VMA_W:35] vma_t;
    typedef enum logic [2:0] {IDLE, REQ, RDWAIT, RDWAIT2, PAUSE, WRDATA, PFAIL} mbox_state_t;
    function automatic logic timed(mbox_state_t s);
        return s inside {REQ, RDWAIT, RDWAIT2, WRDATA};
    endfunction
endpackage

// File: rtl/mcl_mbox_req_if.sv
// mcl_mbox_req_if: MCL request qualifiers, MBOX handshake and EBOX status bundle
interface mcl_mbox_req_if;
    import ebox_mem_pkg::*;
    logic MBOX_CYC_REQ, VMA_READ, VMA_PAUSE, VMA_WRITE, LOAD_AR, LOAD_ARX, VMA_FETCH, VMA_ADR_ERR;
    vma_t VMA;
    word_t AR;
    logic MBOX_ACK, MB_DATA_VALID, MB_WR_DONE, PAGE_FAIL, PF_CLR, ERR_CLR;
    word_t MB_RD_DATA;
    logic EBOX_REQ, REQ_RD, REQ_WR, REQ_FETCH, AR_LOAD, ARX_LOAD, MEM_WAIT, PF_HOLD, NXM_ERR, REQ_OVERRUN;
    vma_t REQ_VMA;
    word_t MB_WR_DATA, MEM_DATA;
    modport slave (
        input MBOX_CYC_REQ, VMA_READ, VMA_PAUSE, VMA_WRITE, LOAD_AR, LOAD_ARX, VMA_FETCH, VMA_ADR_ERR,
        input VMA, AR, MBOX_ACK, MB_DATA_VALID, MB_RD_DATA, MB_WR_DONE, PAGE_FAIL, PF_CLR, ERR_CLR,
        output EBOX_REQ, REQ_VMA, REQ_RD, REQ_WR, REQ_FETCH, MB_WR_DATA, MEM_DATA,
        output AR_LOAD, ARX_LOAD, MEM_WAIT, PF_HOLD, NXM_ERR, REQ_OVERRUN
    );
    modport master (
        output MBOX_CYC_REQ, VMA_READ, VMA_PAUSE, VMA_WRITE, LOAD_AR, LOAD_ARX, VMA_FETCH, VMA_ADR_ERR,
        output VMA, AR, MBOX_ACK, MB_DATA_VALID, MB_RD_DATA, MB_WR_DONE, PAGE_FAIL, PF_CLR, ERR_CLR,
        input EBOX_REQ, REQ_VMA, REQ_RD, REQ_WR, REQ_FETCH, MB_WR_DATA, MEM_DATA,
        input AR_LOAD, ARX_LOAD, MEM_WAIT, PF_HOLD, NXM_ERR, REQ_OVERRUN
    );
endinterface

// File: rtl/mbox_timeout.sv
// mbox_timeout: cycle counter with clear and enable, flagging the last cycle before NXM abort
module mbox_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + CW'(1);
    end
    assign tc = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mcl_mbox_req.sv
// mcl_mbox_req: holds MCL memory cycles as an MBOX request/ack handshake with wait, page-fail and NXM handling
module mcl_mbox_req
    import ebox_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic RESET,
    mcl_mbox_req_if.slave bus
);
    mbox_state_t state, state_n;
    logic rd, wr, pause, ld_ar, ld_arx, fetch, ar_load, arx_load, nxm, overrun;
    logic tc, pf, tmo, mem_wait, rd_word, take_word, ar_n, arx_n, ovr_set;
    vma_t vma_q;
    word_t wdata_q, mem_data;

    mbox_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk), .rst(RESET), .clr(state_n != state), .en(timed(state)), .tc(tc)
    );

    always_comb begin
        mem_wait = timed(state) || state == PFAIL;
        pf = timed(state) && bus.PAGE_FAIL;
        rd_word = (state == RDWAIT || state == RDWAIT2) && bus.MB_DATA_VALID;
        tmo = tc && timed(state) && !pf && !rd_word && !(state == REQ && bus.MBOX_ACK)
            && !(state == WRDATA && bus.MB_WR_DONE);
        // an aborted read still completes its register load, with a zero word
        take_word = (rd_word && !pf) || (tmo && (state == REQ ? rd : state != WRDATA));
        ar_n = take_word && state != RDWAIT2 && ld_ar;
        arx_n = take_word && (state == RDWAIT2 || (!ld_ar && ld_arx));
        ovr_set = bus.MBOX_CYC_REQ && (mem_wait || (state == PAUSE && !bus.VMA_WRITE));
        state_n = state;
        if (pf) state_n = PFAIL;
        else if (tmo) state_n = IDLE;
        else
            case (state)
                IDLE:    if (bus.MBOX_CYC_REQ) state_n = bus.VMA_ADR_ERR ? PFAIL : REQ;
                REQ:     if (bus.MBOX_ACK) state_n = rd ? RDWAIT : wr ? WRDATA : IDLE;
                RDWAIT:  if (bus.MB_DATA_VALID) state_n = (ld_ar && ld_arx) ? RDWAIT2 : pause ? PAUSE : IDLE;
                RDWAIT2: if (bus.MB_DATA_VALID) state_n = pause ? PAUSE : IDLE;
                PAUSE:   if (bus.MBOX_CYC_REQ && bus.VMA_WRITE) state_n = REQ;
                WRDATA:  if (bus.MB_WR_DONE) state_n = IDLE;
                PFAIL:   if (bus.PF_CLR) state_n = IDLE;
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
            {rd, wr, pause, ld_ar, ld_arx, fetch, ar_load, arx_load, nxm, overrun} <= '0;
            vma_q <= '0;
            wdata_q <= '0;
            mem_data <= '0;
        end else begin
            state <= state_n;
            ar_load <= ar_n;
            arx_load <= arx_n;
            if (take_word) mem_data <= tmo ? '0 : bus.MB_RD_DATA;
            if (state == IDLE && state_n == REQ) begin
                vma_q <= bus.VMA;
                wdata_q <= bus.AR;
                rd <= bus.VMA_READ;
                wr <= bus.VMA_WRITE && !bus.VMA_READ;
                pause <= bus.VMA_PAUSE;
                ld_ar <= bus.LOAD_AR;
                ld_arx <= bus.LOAD_ARX;
                fetch <= bus.VMA_FETCH;
            end
            if (state == PAUSE && state_n == REQ) begin
                vma_q <= bus.VMA;
                wdata_q <= bus.AR;
                rd <= 1'b0;
                wr <= 1'b1;
            end
            nxm <= tmo || (nxm && !bus.ERR_CLR);
            overrun <= ovr_set || (overrun && !bus.ERR_CLR);
        end
    end

    assign bus.EBOX_REQ = state == REQ;
    assign bus.REQ_VMA = vma_q;
    assign bus.REQ_RD = rd;
    assign bus.REQ_WR = wr;
    assign bus.REQ_FETCH = fetch;
    assign bus.MB_WR_DATA = wdata_q;
    assign bus.MEM_DATA = mem_data;
    assign bus.AR_LOAD = ar_load;
    assign bus.ARX_LOAD = arx_load;
    assign bus.MEM_WAIT = mem_wait;
    assign bus.PF_HOLD = state == PFAIL;
    assign bus.NXM_ERR = nxm;
    assign bus.REQ_OVERRUN = overrun;
endmodule

// File: tb/tb_mcl_mbox_req.sv
// tb_mcl_mbox_req: directed and random checks of mcl_mbox_req against a transaction-level model
module tb_mcl_mbox_req;
    import ebox_mem_pkg::*;
    localparam int TMO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mcl_mbox_req_if b();
    mcl_mbox_req #(.TIMEOUT(TMO)) dut (.clk(clk), .RESET(rst), .bus(b));
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit m_req, m_rd, m_wr, m_pq, m_lar, m_larx, m_fetch, m_wr_wait, m_paused, m_pf, m_nxm, m_ovr, m_ar_ld, m_arx_ld;
    int m_age;
    int dq[$];
    vma_t m_vma;
    word_t m_wdata, m_mem;
    logic [104:0] dut_v;

    assign dut_v = {b.EBOX_REQ, b.REQ_VMA, b.REQ_RD, b.REQ_WR, b.REQ_FETCH, b.MB_WR_DATA, b.MEM_DATA,
                    b.AR_LOAD, b.ARX_LOAD, b.MEM_WAIT, b.PF_HOLD, b.NXM_ERR, b.REQ_OVERRUN};

    function automatic logic [104:0] mdl_v();
        bit busy = m_req || dq.size() > 0 || m_wr_wait || m_pf;
        return {m_req, m_vma, m_rd, m_wr, m_fetch, m_wdata, m_mem, m_ar_ld, m_arx_ld, busy, m_pf, m_nxm, m_ovr};
    endfunction

    // dq holds the destinations of read words still owed by the MBOX: 0 none, 1 AR, 2 ARX
    task automatic model_step();
        bit outstanding, prog, nset, oset;
        int d;
        outstanding = m_req || dq.size() > 0 || m_wr_wait;
        m_ar_ld = 0;
        m_arx_ld = 0;
        if (rst) begin
            {m_req, m_rd, m_wr, m_pq, m_lar, m_larx, m_fetch, m_wr_wait, m_paused, m_pf, m_nxm, m_ovr} = '0;
            m_age = 0;
            dq.delete();
            m_vma = '0;
            m_wdata = '0;
            m_mem = '0;
            return;
        end
        nset = 0;
        oset = b.MBOX_CYC_REQ && (outstanding || m_pf || (m_paused && !b.VMA_WRITE));
        if (outstanding) begin
            prog = m_req ? b.MBOX_ACK : dq.size() > 0 ? b.MB_DATA_VALID : b.MB_WR_DONE;
            if (b.PAGE_FAIL) begin
                m_req = 0; dq.delete(); m_wr_wait = 0; m_pf = 1;
            end else if (prog) begin
                m_age = 0;
                if (m_req) begin
                    m_req = 0;
                    if (m_rd) begin
                        if (m_lar) dq.push_back(1);
                        if (m_larx) dq.push_back(2);
                        if (dq.size() == 0) dq.push_back(0);
                    end else if (m_wr) m_wr_wait = 1;
                end else if (dq.size() > 0) begin
                    d = dq.pop_front();
                    m_mem = b.MB_RD_DATA;
                    m_ar_ld = d == 1;
                    m_arx_ld = d == 2;
                    if (dq.size() == 0 && m_pq) m_paused = 1;
                end else m_wr_wait = 0;
            end else if (m_age == TMO - 1) begin
                nset = 1;
                if (dq.size() > 0 || (m_req && m_rd)) begin
                    d = dq.size() > 0 ? dq[0] : m_lar ? 1 : m_larx ? 2 : 0;
                    m_mem = '0;
                    m_ar_ld = d == 1;
                    m_arx_ld = d == 2;
                end
                m_req = 0; dq.delete(); m_wr_wait = 0;
            end else m_age++;
        end else if (m_pf) m_pf = !b.PF_CLR;
        else if (m_paused) begin
            if (b.MBOX_CYC_REQ && b.VMA_WRITE) begin
                m_vma = b.VMA; m_wdata = b.AR; m_rd = 0; m_wr = 1; m_paused = 0; m_req = 1; m_age = 0;
            end
        end else if (b.MBOX_CYC_REQ) begin
            if (b.VMA_ADR_ERR) m_pf = 1;
            else begin
                m_vma = b.VMA; m_wdata = b.AR; m_rd = b.VMA_READ; m_wr = b.VMA_WRITE && !b.VMA_READ;
                m_pq = b.VMA_PAUSE; m_lar = b.LOAD_AR; m_larx = b.LOAD_ARX; m_fetch = b.VMA_FETCH;
                m_req = 1; m_age = 0;
            end
        end
        m_nxm = nset || (m_nxm && !b.ERR_CLR);
        m_ovr = oset || (m_ovr && !b.ERR_CLR);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        n_chk++;
        if (dut_v === mdl_v()) n_pass++;
        else $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, dut_v, mdl_v());
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic clr_in();
        {b.MBOX_CYC_REQ, b.VMA_READ, b.VMA_PAUSE, b.VMA_WRITE, b.LOAD_AR, b.LOAD_ARX, b.VMA_FETCH, b.VMA_ADR_ERR} = '0;
        {b.MBOX_ACK, b.MB_DATA_VALID, b.MB_WR_DONE, b.PAGE_FAIL, b.PF_CLR, b.ERR_CLR} = '0;
        b.VMA = '0;
        b.AR = '0;
        b.MB_RD_DATA = '0;
    endtask

    task automatic cyc(bit rq, bit wq, bit pq, bit la, bit lx, vma_t v, word_t a);
        clr_in();
        b.MBOX_CYC_REQ = 1; b.VMA_READ = rq; b.VMA_WRITE = wq; b.VMA_PAUSE = pq;
        b.LOAD_AR = la; b.LOAD_ARX = lx; b.VMA = v; b.AR = a;
        tick();
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1;
        model_step();
        @(negedge clk);
        tick();
        rst = 0;
        chk("rst_wait", b.MEM_WAIT, 0);
        chk("rst_req", b.EBOX_REQ, 0);
        // read into AR, ack in the third request cycle
        cyc(1, 0, 0, 1, 0, 23'o1000, '0);
        chk("rd_req1", b.EBOX_REQ, 1);
        chk("rd_vma", b.REQ_VMA, 23'o1000);
        tick();
        chk("rd_req2", b.EBOX_REQ, 1);
        tick();
        chk("rd_req3", b.EBOX_REQ, 1);
        b.MBOX_ACK = 1; tick(); clr_in();
        chk("rd_req_drop", b.EBOX_REQ, 0);
        chk("rd_wait", b.MEM_WAIT, 1);
        b.MB_DATA_VALID = 1; b.MB_RD_DATA = 36'o123456701234; tick(); clr_in();
        chk("rd_arload", b.AR_LOAD, 1);
        chk("rd_arxload", b.ARX_LOAD, 0);
        chk("rd_data", b.MEM_DATA, 36'o123456701234);
        chk("rd_idle", b.MEM_WAIT, 0);
        tick();
        chk("rd_strobe_end", b.AR_LOAD, 0);
        // write
        cyc(0, 1, 0, 0, 0, 23'o2000, 36'o777777000000);
        chk("wr_reqwr", b.REQ_WR, 1);
        chk("wr_reqrd", b.REQ_RD, 0);
        b.MBOX_ACK = 1; tick(); clr_in();
        tick();
        chk("wr_hold", b.MB_WR_DATA, 36'o777777000000);
        chk("wr_wait", b.MEM_WAIT, 1);
        b.MB_WR_DONE = 1; tick(); clr_in();
        chk("wr_idle", b.MEM_WAIT, 0);
        chk("wr_nostrobe", {b.AR_LOAD, b.ARX_LOAD}, 0);
        // read-pause-write
        cyc(1, 0, 1, 1, 0, 23'o3000, '0);
        b.MBOX_ACK = 1; tick(); clr_in();
        b.MB_DATA_VALID = 1; b.MB_RD_DATA = 36'd5; tick(); clr_in();
        chk("rpw_arload", b.AR_LOAD, 1);
        chk("rpw_data", b.MEM_DATA, 5);
        chk("rpw_run", b.MEM_WAIT, 0);
        cyc(1, 0, 0, 1, 0, 23'o3000, '0);
        chk("rpw_overrun", b.REQ_OVERRUN, 1);
        chk("rpw_stay", b.EBOX_REQ, 0);
        cyc(0, 1, 0, 0, 0, 23'o3000, 36'd6);
        chk("rpw_wrreq", b.EBOX_REQ, 1);
        chk("rpw_wr", b.REQ_WR, 1);
        chk("rpw_wdata", b.MB_WR_DATA, 6);
        b.MBOX_ACK = 1; tick(); clr_in();
        b.MB_WR_DONE = 1; tick(); clr_in();
        b.ERR_CLR = 1; tick(); clr_in();
        chk("errclr_ovr", b.REQ_OVERRUN, 0);
        // page fail beats data
        cyc(1, 0, 0, 1, 0, 23'o4000, '0);
        b.MBOX_ACK = 1; tick(); clr_in();
        b.MB_DATA_VALID = 1; b.MB_RD_DATA = 36'o111; b.PAGE_FAIL = 1; tick(); clr_in();
        chk("pf_noload", b.AR_LOAD, 0);
        chk("pf_hold", b.PF_HOLD, 1);
        chk("pf_noreq", b.EBOX_REQ, 0);
        chk("pf_data", b.MEM_DATA, 5);
        b.PF_CLR = 1; tick(); clr_in();
        chk("pf_clr", {b.PF_HOLD, b.MEM_WAIT}, 0);
        b.MBOX_CYC_REQ = 1; b.VMA_READ = 1; b.VMA_ADR_ERR = 1; tick(); clr_in();
        chk("adr_pf", b.PF_HOLD, 1);
        chk("adr_noreq", b.EBOX_REQ, 0);
        b.PF_CLR = 1; tick(); clr_in();
        // NXM timeout
        cyc(1, 0, 0, 1, 0, 23'o5000, '0);
        repeat (TMO - 1) tick();
        chk("tmo_req8", b.EBOX_REQ, 1);
        chk("tmo_pre", b.NXM_ERR, 0);
        tick();
        chk("tmo_nxm", b.NXM_ERR, 1);
        chk("tmo_arload", b.AR_LOAD, 1);
        chk("tmo_data", b.MEM_DATA, 0);
        chk("tmo_noreq", b.EBOX_REQ, 0);
        b.ERR_CLR = 1; tick(); clr_in();
        chk("tmo_clr", b.NXM_ERR, 0);
        cyc(1, 0, 0, 1, 0, 23'o5000, '0);
        repeat (TMO - 1) tick();
        b.ERR_CLR = 1; tick(); clr_in();
        chk("tmo_set_wins", b.NXM_ERR, 1);
        // reset during read wait
        cyc(1, 0, 0, 1, 1, 23'o6000, '0);
        b.MBOX_ACK = 1; tick(); clr_in();
        rst = 1; tick(); rst = 0;
        chk("rst_all_zero", 64'(dut_v != '0), 0);
        b.MB_DATA_VALID = 1; b.MB_RD_DATA = 36'o7; tick(); clr_in();
        chk("rst_nostrobe", {b.AR_LOAD, b.ARX_LOAD}, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(299) == 0;
            b.MBOX_CYC_REQ = $urandom_range(99) < 30;
            b.VMA_READ = $urandom_range(99) < 60;
            b.VMA_PAUSE = $urandom_range(99) < 30;
            b.VMA_WRITE = $urandom_range(99) < 50;
            b.LOAD_AR = $urandom_range(99) < 50;
            b.LOAD_ARX = $urandom_range(99) < 40;
            b.VMA_FETCH = $urandom_range(99) < 20;
            b.VMA_ADR_ERR = $urandom_range(99) < 5;
            b.VMA = vma_t'($urandom);
            b.AR = word_t'({$urandom, $urandom});
            b.MB_RD_DATA = word_t'({$urandom, $urandom});
            b.MBOX_ACK = $urandom_range(99) < 30;
            b.MB_DATA_VALID = $urandom_range(99) < 30;
            b.MB_WR_DONE = $urandom_range(99) < 30;
            b.PAGE_FAIL = $urandom_range(99) < 3;
            b.PF_CLR = $urandom_range(99) < 30;
            b.ERR_CLR = $urandom_range(99) < 10;
            tick();
        end
        rst = 0;
        clr_in();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
